// File: rtl/gf1543_mul_prefold.sv
// gf1543_mul_prefold
// Two-stage modular-multiply front end for GF(1543). Stage S1 forms the full
// 22-bit product of two 11-bit operands; stage S2 folds it into a congruent
// 21-bit value that fits the downstream Barrett reducer input. Out-of-range
// operand pairs are flagged, zeroed and counted. Valid/ready handshake on both
// sides with a combinational ready path, so a full pipeline accepts and emits
// in the same cycle.

module gf1543_mul_prefold #(
   parameter int Q     = 1543,
   parameter int W     = 11,
   parameter int PW    = 21,
   parameter int TAG_W = 4,
   parameter int FOLD  = 1580032
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PW-1:0]    out_prod,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [7:0]       err_cnt,
   output logic             busy
);

   // Full product width; one bit wider than the reducer input.
   localparam int PPW = 2 * W;

   localparam logic [W-1:0]   Q_W    = W'(Q);
   localparam logic [PPW-1:0] FOLD_P = PPW'(FOLD);

   // Fold a full product into PW bits. FOLD is Q<<10, so subtracting it keeps
   // the residue mod Q. Any product with the top bit set exceeds FOLD, so the
   // subtraction never wraps, and the largest legal product lands well below
   // 2^PW.
   function automatic logic [PW-1:0] fold_prod(input logic [PPW-1:0] p);
      logic [PPW-1:0] d;
      if (p[PPW-1]) begin
         d = p - FOLD_P;
      end else begin
         d = p;
      end
      return d[PW-1:0];
   endfunction

   // Stage S1 state
   logic             r_s1_v;
   logic [PPW-1:0]   r_s1_p;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s1_err;

   // Stage S2 state (drives the outputs directly)
   logic             r_s2_v;
   logic [PW-1:0]    r_s2_prod;
   logic [TAG_W-1:0] r_s2_tag;
   logic             r_s2_err;

   logic [7:0]       r_err_cnt;

   // Handshake and datapath wires
   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_accept;
   logic             w_in_err;
   logic [PPW-1:0]   w_prod;
   logic [PPW-1:0]   w_s1_p_next;

   // Stall logic: a stage advances when it is empty or its consumer advances.
   always_comb begin
      w_s2_adv = !r_s2_v || out_ready;
      w_s1_adv = !r_s1_v || w_s2_adv;
      w_accept = in_valid && w_s1_adv;
   end

   // Operand range check and product; an out-of-range pair yields a zero product.
   always_comb begin
      w_in_err = (in_a >= Q_W) || (in_b >= Q_W);
      w_prod   = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
      if (w_in_err) begin
         w_s1_p_next = {PPW{1'b0}};
      end else begin
         w_s1_p_next = w_prod;
      end
   end

   // S1 register: load a new pair on accept, otherwise hold or empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v   <= 1'b0;
         r_s1_p   <= {PPW{1'b0}};
         r_s1_tag <= {TAG_W{1'b0}};
         r_s1_err <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_s1_p   <= w_s1_p_next;
            r_s1_tag <= in_tag;
            r_s1_err <= w_in_err;
         end else begin
            r_s1_p   <= r_s1_p;
            r_s1_tag <= r_s1_tag;
            r_s1_err <= r_s1_err;
         end
      end else begin
         r_s1_v   <= r_s1_v;
         r_s1_p   <= r_s1_p;
         r_s1_tag <= r_s1_tag;
         r_s1_err <= r_s1_err;
      end
   end

   // S2 register: take the folded S1 product when S2 can advance; hold while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v    <= 1'b0;
         r_s2_prod <= {PW{1'b0}};
         r_s2_tag  <= {TAG_W{1'b0}};
         r_s2_err  <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_prod <= fold_prod(r_s1_p);
            r_s2_tag  <= r_s1_tag;
            r_s2_err  <= r_s1_err;
         end else begin
            r_s2_prod <= r_s2_prod;
            r_s2_tag  <= r_s2_tag;
            r_s2_err  <= r_s2_err;
         end
      end else begin
         r_s2_v    <= r_s2_v;
         r_s2_prod <= r_s2_prod;
         r_s2_tag  <= r_s2_tag;
         r_s2_err  <= r_s2_err;
      end
   end

   // Saturating count of accepted out-of-range pairs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= 8'd0;
      end else if (w_accept && w_in_err && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
         r_err_cnt <= r_err_cnt;
      end
   end

   // Output mapping: data outputs come straight from registers.
   always_comb begin
      in_ready  = w_s1_adv;
      out_valid = r_s2_v;
      out_prod  = r_s2_prod;
      out_tag   = r_s2_tag;
      out_err   = r_s2_err;
      err_cnt   = r_err_cnt;
      busy      = r_s1_v || r_s2_v;
   end

endmodule

// File: tb/tb_gf1543_mul_prefold.sv
// Self-checking bench for gf1543_mul_prefold: directed corner cases plus a
// randomized stream compared against a queue-based reference model.

module tb_gf1543_mul_prefold;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_a;
   logic [10:0] in_b;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [20:0] out_prod;
   logic [3:0]  out_tag;
   logic        out_err;
   logic [7:0]  err_cnt;
   logic        busy;

   gf1543_mul_prefold dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_tag   (out_tag),
      .out_err   (out_err),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] a;
      logic [10:0] b;
      logic [3:0]  tag;
   } pair_t;

   pair_t       q[$];
   int          n_vec    = 0;
   int          n_err    = 0;
   int          n_out    = 0;
   int          exp_cnt  = 0;
   bit          last_acc = 1'b0;
   bit          blk_seen = 1'b0;
   bit          hold_pend = 1'b0;
   logic [20:0] h_prod;
   logic [3:0]  h_tag;
   logic        h_err;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: exact product, reduced past 2^21 by the Q<<10 fold.
   function automatic int ref_prod(input int a, input int b);
      int p;
      if (a >= 1543 || b >= 1543) return 0;
      p = a * b;
      if (p >= (1 << 21)) p = p - 1543 * 1024;
      return p;
   endfunction

   // Observe one cycle at the falling edge, then advance to just after the rising edge.
   task automatic tick();
      pair_t e;
      @(negedge clk);
      if (hold_pend) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_prod", 32'(out_prod), 32'(h_prod));
         chk("hold_tag", 32'(out_tag), 32'(h_tag));
         chk("hold_err", 32'(out_err), 32'(h_err));
      end
      hold_pend = out_valid && !out_ready;
      h_prod = out_prod;
      h_tag  = out_tag;
      h_err  = out_err;
      if (in_valid && !in_ready) blk_seen = 1'b1;
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         e.a = in_a; e.b = in_b; e.tag = in_tag;
         q.push_back(e);
         if ((int'(in_a) >= 1543 || int'(in_b) >= 1543) && exp_cnt < 255) exp_cnt++;
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            chk("spurious_out", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("prod", 32'(out_prod), 32'(ref_prod(int'(e.a), int'(e.b))));
            chk("tag", 32'(out_tag), 32'(e.tag));
            chk("err", 32'(out_err), 32'((int'(e.a) >= 1543) || (int'(e.b) >= 1543)));
            if (int'(e.a) < 1543 && int'(e.b) < 1543)
               chk("residue", 32'(int'(out_prod) % 1543), 32'((int'(e.a) * int'(e.b)) % 1543));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // One pair into an empty pipeline with out_ready high: check exact latency and value.
   task automatic lat_test(input int a, input int b, input int tag, input int exp_p, input int exp_e);
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 11'(a); in_b = 11'(b); in_tag = 4'(tag);
      tick();
      chk("lat_accept", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
      chk("lat_early", 32'(out_valid), 32'd0);
      tick();
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_prod", 32'(out_prod), 32'(exp_p));
      chk("lat_tag", 32'(out_tag), 32'(tag));
      chk("lat_err", 32'(out_err), 32'(exp_e));
      tick();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) tick();
      chk("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      int idx;
      int n0;
      int acc;
      rst = 1'b1; in_valid = 1'b0; in_a = 11'd0; in_b = 11'd0; in_tag = 4'd0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_prod", 32'(out_prod), 32'd0);
      rst = 1'b0;
      tick();

      // Directed values
      lat_test(3, 5, 2, 15, 0);
      lat_test(1542, 1542, 9, 797732, 0);
      lat_test(1448, 1448, 3, 2096704, 0);
      lat_test(1449, 1448, 4, 518120, 0);
      lat_test(1543, 7, 5, 0, 1);
      chk("err_cnt_one", 32'(err_cnt), 32'd1);

      // 300 out-of-range pairs back to back: counter must saturate
      out_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 400 && acc < 300; i++) begin
         in_valid = 1'b1;
         in_a = 11'($urandom_range(1543, 2047));
         in_b = 11'($urandom_range(0, 2047));
         in_tag = 4'($urandom_range(0, 15));
         tick();
         if (last_acc) acc++;
      end
      drain();
      chk("err_cnt_sat", 32'(err_cnt), 32'd255);
      chk("err_cnt_model", 32'(err_cnt), 32'(exp_cnt));

      // Eight-pair stream with out_ready low in cycles 3..6
      idx = 0; n0 = n_out; blk_seen = 1'b0;
      for (int k = 0; k < 40 && (n_out - n0) < 8; k++) begin
         out_ready = !(k >= 3 && k <= 6);
         if (idx < 8) begin
            in_valid = 1'b1;
            in_a = 11'($urandom_range(0, 1542));
            in_b = 11'($urandom_range(0, 1542));
            in_tag = 4'(idx);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (last_acc) idx++;
      end
      chk("stream_count", 32'(n_out - n0), 32'd8);
      chk("stream_blocked", 32'(blk_seen), 32'd1);
      drain();

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 800; i++) begin
         if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(1543, 2047))
                 : ($urandom_range(0, 7) == 0) ? 11'd1542 : 11'($urandom_range(0, 1542));
            in_b = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(1543, 2047))
                 : 11'($urandom_range(1300, 1542));
            in_tag = 4'($urandom_range(0, 15));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();
      chk("err_cnt_rand", 32'(err_cnt), 32'(exp_cnt));

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 11'd100; in_b = 11'd200; in_tag = 4'd7;
      for (int i = 0; i < 10 && in_ready; i++) tick();
      in_valid = 1'b0;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_err_cnt", 32'(err_cnt), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      exp_cnt = 0;
      hold_pend = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      lat_test(1000, 1500, 11, 1500000, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #500000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "time limit reached");
   end

endmodule
